// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2-read/1-write integer register file with sequenced post-reset clear.
// Optional write-first forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_2r1w #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            busy,
    output logic            wr_err
);
    localparam logic [0:0]  CLEAR = 1'b0;
    localparam logic [0:0]  READY = 1'b1;
    localparam bit          ZR    = ZERO_REG != 0;
    localparam logic [AW:0] LAST  = (AW+1)'((1 << AW) - 1);

    logic [0:0]      state;
    logic [AW:0]     ptr;
    logic [XLEN-1:0] mem [1 << AW];
    logic            wr_zero;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            fwd1;
    logic            fwd2;

    assign busy    = state == CLEAR;
    assign wr_zero = ZR && waddr == '0;

    // Storage port is shared between the clear sequencer and the writeback port
    always_comb begin
        mem_we   = rst_n && (busy || (we && !wr_zero));
        mem_addr = busy ? ptr[AW-1:0] : waddr;
        mem_data = busy ? '0 : wdata;
    end

    // Clear sequencer and write-while-busy error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= CLEAR;
            ptr    <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= we && busy;
            if (busy) begin
                ptr <= ptr + 1'b1;
                if (ptr == LAST) state <= READY;
            end
        end
    end

    // Storage array has no reset; contents are zeroed by the clear sequence
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = !busy && we && !wr_zero && waddr == raddr1;
    assign fwd2 = !busy && we && !wr_zero && waddr == raddr2;
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    // Read ports: busy and hardwired zero take priority over forwarding
    always_comb begin
        rdata1 = busy || (ZR && raddr1 == '0) ? '0 : fwd1 ? wdata : mem[raddr1];
        rdata2 = busy || (ZR && raddr2 == '0) ? '0 : fwd2 ? wdata : mem[raddr2];
    end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed-vector bench for reg_file_2r1w (default, ZERO_REG=0 and AW=3 instances).
module tb_reg_file_2r1w;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, we, busy, wr_err, z_busy, z_wr_err;
    logic [4:0]  waddr, raddr1, raddr2;
    logic [31:0] wdata, rdata1, rdata2, z_rdata1, z_rdata2;
    logic        s_we, s_busy, s_wr_err;
    logic [2:0]  s_waddr, s_raddr1, s_raddr2;
    logic [15:0] s_wdata, s_rdata1, s_rdata2;

    int vectors = 0;
    int miscompares = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_file_2r1w dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .busy(busy), .wr_err(wr_err)
    );

    reg_file_2r1w #(.ZERO_REG(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(z_rdata1), .rdata2(z_rdata2),
        .busy(z_busy), .wr_err(z_wr_err)
    );

    reg_file_2r1w #(.XLEN(16), .AW(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
        .raddr1(s_raddr1), .raddr2(s_raddr2), .rdata1(s_rdata1), .rdata2(s_rdata2),
        .busy(s_busy), .wr_err(s_wr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_raddr1 = '0; s_raddr2 = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_rdata2", rdata2, 32'd0);
        check("rst_s_busy", 32'(s_busy), 32'd1);

        rst_n = 1'b1; raddr1 = 5'd5; raddr2 = 5'd31;
        for (int i = 0; i < 32; i++) begin
            we      = (i == 10 || i == 31);
            waddr   = (i == 10) ? 5'd7 : 5'd9;
            wdata   = (i == 10) ? 32'hA5A5_A5A5 : 32'h0000_0BAD;
            s_we    = (i == 8);
            s_waddr = 3'd7; s_wdata = 16'hFFFF;
            #1;
            check("clr_busy", 32'(busy), 32'd1);
            check("clr_rdata1", rdata1, 32'd0);
            check("clr_rdata2", rdata2, 32'd0);
            check("s_busy", 32'(s_busy), 32'(i < 8));
            tick();
            check("clr_wr_err", 32'(wr_err), 32'(i == 10 || i == 31));
            check("s_wr_err", 32'(s_wr_err), 32'd0);
        end
        we = 1'b0; s_we = 1'b0; s_raddr1 = 3'd7; s_raddr2 = 3'd0;
        #1;
        check("ready_busy", 32'(busy), 32'd0);
        check("last_edge_wr_err", 32'(wr_err), 32'd1);
        check("s_x7", 32'(s_rdata1), 32'h0000_FFFF);
        check("s_x0", 32'(s_rdata2), 32'd0);
        tick();
        check("wr_err_clears", 32'(wr_err), 32'd0);

        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #1;
            check("cleared_rd1", rdata1, 32'd0);
            check("cleared_rd2", rdata2, 32'd0);
            tick();
        end

        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd5; raddr2 = 5'd5;
        #1;
        check("x5_same_cycle", rdata1, BYP ? 32'hDEAD_BEEF : 32'd0);
        tick();
        we = 1'b0;
        #1;
        check("x5_rd1", rdata1, 32'hDEAD_BEEF);
        check("x5_rd2", rdata2, 32'hDEAD_BEEF);
        check("x5_wr_err", 32'(wr_err), 32'd0);

        we = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234; raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        check("x0_fwd_zero", rdata1, 32'd0);
        check("z_x0_fwd", z_rdata1, BYP ? 32'h0000_1234 : 32'd0);
        tick();
        we = 1'b0;
        #1;
        check("x0_zero", rdata1, 32'd0);
        check("z_x0_rd1", z_rdata1, 32'h0000_1234);
        check("z_x0_rd2", z_rdata2, 32'h0000_1234);

        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0055; raddr1 = 5'd9; raddr2 = 5'd5;
        #1;
        check("x9_bypass", rdata1, BYP ? 32'h0000_0055 : 32'd0);
        check("x5_other_port", rdata2, 32'hDEAD_BEEF);
        tick();
        we = 1'b0;
        #1;
        check("x9_next", rdata1, 32'h0000_0055);

        we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0077;
        tick();
        we = 1'b0; raddr1 = 5'd3;
        #1;
        check("x3_written", rdata1, 32'h0000_0077);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("reclr_busy", 32'(busy), 32'd1);
            tick();
        end
        rst_n = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0099;
        tick();
        check("rst_mid_wr_err", 32'(wr_err), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b1; we = 1'b0; raddr2 = 5'd5;
        for (int i = 0; i < 32; i++) begin
            #1;
            check("restart_busy", 32'(busy), 32'd1);
            tick();
        end
        #1;
        check("restart_done", 32'(busy), 32'd0);
        check("x3_after_clear", rdata1, 32'd0);
        check("x5_after_clear", rdata2, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
